// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
// Provides the word and cache-line types used across the memory hierarchy,
// plus the types and constants of the I/D cache arbiter: its FSM state
// enum, the one-hot grant typedef and the GRANT_* constants.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

  // One-hot owner of the memory port: bit0 = I side, bit1 = D side.
  typedef logic [1:0] arb_grant_t;

  localparam arb_grant_t GRANT_NONE = 2'b00;
  localparam arb_grant_t GRANT_I    = 2'b01;
  localparam arb_grant_t GRANT_D    = 2'b10;

endpackage

// File: rtl/cache_arbiter_mux.sv
// Combinational 2:1 port mux of the cache arbiter.
// Selects the granted requester's address, write line and strobes onto the
// lower-level memory port. With no grant the port is driven to all zeros.
// Ports:
//   grant                                  one-hot owner (GRANT_NONE/I/D)
//   i_address, i_wdata, i_read, i_write    I-side request
//   d_address, d_wdata, d_read, d_write    D-side request
//   mem_address, mem_wdata, mem_read,
//   mem_write                              selected request to memory
module cache_arbiter_mux
  import lc3b_types::*;
(
  input  arb_grant_t     grant,
  input  lc3b_word       i_address,
  input  lc3b_cache_line i_wdata,
  input  logic           i_read,
  input  logic           i_write,
  input  lc3b_word       d_address,
  input  lc3b_cache_line d_wdata,
  input  logic           d_read,
  input  logic           d_write,
  output lc3b_word       mem_address,
  output lc3b_cache_line mem_wdata,
  output logic           mem_read,
  output logic           mem_write
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would infer a latch.
    mem_address = 16'h0000;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (grant)
      GRANT_I: begin
        mem_address = i_address;
        mem_wdata   = i_wdata;
        mem_read    = i_read;
        mem_write   = i_write;
      end
      GRANT_D: begin
        mem_address = d_address;
        mem_wdata   = d_wdata;
        mem_read    = d_read;
        mem_write   = d_write;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-port arbiter sharing the single cache-line memory port below the L1
// between the instruction-side and data-side miss/writeback paths.
// One side is granted at a time and holds the grant until mem_resp (or
// until it drops its request); the response is routed only to the owner
// and one IDLE cycle separates consecutive grants.
// Build option: define CACHE_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking (side not last served wins); otherwise D always wins a tie.
// Ports:
//   clk, reset (synchronous, active-high)
//   i_address/i_wdata/i_read/i_write -> i_rdata/i_resp   I-side port
//   d_address/d_wdata/d_read/d_write -> d_rdata/d_resp   D-side port
//   mem_address/mem_wdata/mem_read/mem_write <- mem_rdata/mem_resp
//   grant  one-hot owner, 2'b00 when idle
module cache_arbiter
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset,
  input  lc3b_word       i_address,
  input  lc3b_cache_line i_wdata,
  input  logic           i_read,
  input  logic           i_write,
  output lc3b_cache_line i_rdata,
  output logic           i_resp,
  input  lc3b_word       d_address,
  input  lc3b_cache_line d_wdata,
  input  logic           d_read,
  input  logic           d_write,
  output lc3b_cache_line d_rdata,
  output logic           d_resp,
  output lc3b_word       mem_address,
  output lc3b_cache_line mem_wdata,
  output logic           mem_read,
  output logic           mem_write,
  input  lc3b_cache_line mem_rdata,
  input  logic           mem_resp,
  output arb_grant_t     grant
);

  arb_state_t state;
  arb_state_t state_next;
  logic       i_active;
  logic       d_active;
  logic       tie_to_d;

  assign i_active = i_read | i_write;
  assign d_active = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // 0 = I was granted last, 1 = D was granted last.
  logic last_served;

  always_ff @(posedge clk) begin
    if (reset)
      last_served <= 1'b0;
    else if (state == IDLE && state_next != IDLE)
      last_served <= (state_next == SERVE_D);
  end

  assign tie_to_d = ~last_served;
`else
  assign tie_to_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_active && d_active)
          state_next = tie_to_d ? SERVE_D : SERVE_I;
        else if (d_active)
          state_next = SERVE_D;
        else if (i_active)
          state_next = SERVE_I;
      end
      // Completion or a dropped request both release the port.
      SERVE_I: if (mem_resp || !i_active) state_next = IDLE;
      SERVE_D: if (mem_resp || !d_active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant = GRANT_NONE;
    case (state)
      SERVE_I: grant = GRANT_I;
      SERVE_D: grant = GRANT_D;
      default: ;
    endcase
  end

  // Response goes only to the owner; a late mem_resp in IDLE is dropped.
  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  cache_arbiter_mux u_mux (
    .grant       (grant),
    .i_address   (i_address),
    .i_wdata     (i_wdata),
    .i_read      (i_read),
    .i_write     (i_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_read      (d_read),
    .d_write     (d_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write)
  );

endmodule
